// File: rtl/ext_pkg.sv
// Shared definitions for the immediate/load-extension pipeline.
package ext_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_SIGN      = 4'd0;
  localparam logic [OP_W-1:0] OP_ZERO      = 4'd1;
  localparam logic [OP_W-1:0] OP_HIGH      = 4'd2;
  localparam logic [OP_W-1:0] OP_SIGN_SHL2 = 4'd3;
  localparam logic [OP_W-1:0] OP_LB        = 4'd4;
  localparam logic [OP_W-1:0] OP_LBU       = 4'd5;
  localparam logic [OP_W-1:0] OP_LH        = 4'd6;
  localparam logic [OP_W-1:0] OP_LHU       = 4'd7;
  localparam logic [OP_W-1:0] OP_LW        = 4'd8;

  // Occupancy of the output register / skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_e;

  // Byte-offset width for a DATA_W-bit memory word.
  function automatic int unsigned off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extension unit: immediate forms and load-lane sign/zero extension.
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]             op,
  input  logic [IMM_W-1:0]            imm,
  input  logic [DATA_W-1:0]           data,
  input  logic [off_w(DATA_W)-1:0]    off,
  output logic [DATA_W-1:0]           res_c,
  output logic                        err_c
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] imm_sext;

  // Addressed byte/halfword/word ends up in the low bits of lane.
  assign lane     = data >> {off, 3'b000};
  assign imm_sext = DATA_W'($signed(imm));

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (op)
      OP_SIGN:      res_c = imm_sext;
      OP_ZERO:      res_c = DATA_W'(imm);
      OP_HIGH:      res_c = DATA_W'(imm) << (DATA_W - IMM_W);
      OP_SIGN_SHL2: res_c = imm_sext << 2;
      OP_LB:        res_c = DATA_W'($signed(lane[7:0]));
      OP_LBU:       res_c = DATA_W'(lane[7:0]);
      OP_LH: begin
        if (off[0]) err_c = 1'b1;
        else        res_c = DATA_W'($signed(lane[15:0]));
      end
      OP_LHU: begin
        if (off[0]) err_c = 1'b1;
        else        res_c = DATA_W'(lane[15:0]);
      end
      OP_LW: begin
        if (off[1:0] != 2'b00) err_c = 1'b1;
        else                   res_c = DATA_W'($signed(lane[31:0]));
      end
      default:      err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Extension unit behind a two-slot (output + skid) valid/ready buffer with error counter.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             in_op,
  input  logic [IMM_W-1:0]            in_imm,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [off_w(DATA_W)-1:0]    in_off,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_err,
  output logic [TAG_W-1:0]            out_tag,
  output logic [CNT_W-1:0]            err_cnt
);

  logic [DATA_W-1:0] core_data_c;
  logic              core_err_c;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .op    (in_op),
    .imm   (in_imm),
    .data  (in_data),
    .off   (in_off),
    .res_c (core_data_c),
    .err_c (core_err_c)
  );

  slot_state_e       state, state_nxt;
  logic              accept, drain;
  logic              load_out_new, load_out_skid, load_skid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic [TAG_W-1:0]  skid_tag;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Slot occupancy next-state and datapath load selects.
  always_comb begin
    state_nxt     = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt     = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flags are registered copies of the next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      skid_tag  <= '0;
    end else begin
      if (load_out_new) begin
        out_data <= core_data_c;
        out_err  <= core_err_c;
        out_tag  <= in_tag;
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
        out_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= core_data_c;
        skid_err  <= core_err_c;
        skid_tag  <= in_tag;
      end
    end
  end

  // Saturating count of errored output transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (drain && out_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
